// File: rtl/fb_write_scheduler_if.sv
// Pixel requester bundle for fb_write_scheduler.
// Two requesters share the bundle: bit/field 0 is the tile renderer, bit/field 1 the sprite engine.
// The master side is the renderer pair; the slave side is the scheduler.
interface fb_write_scheduler_if;
    logic [1:0]  req_valid;  // per-requester pixel valid
    logic [15:0] req_x;      // {x1, x0} row index
    logic [17:0] req_y;      // {y1, y0} column index
    logic [15:0] req_color;  // {c1, c0}
    logic [1:0]  req_done;   // level: requester finished this frame
    logic [1:0]  req_ready;  // per-requester accept

    modport master (
        output req_valid,
        output req_x,
        output req_y,
        output req_color,
        output req_done,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_x,
        input  req_y,
        input  req_color,
        input  req_done,
        output req_ready
    );
endinterface

// File: rtl/fb_write_scheduler.sv
// Write-side scheduler for the ping-pong VGA frame buffer.
// The back bank is written every cycle, so the address is parked on an unused location whenever
// no real write is wanted. Each bank swap triggers a full clear sweep of the new back bank,
// followed by round-robin drawing from the tile renderer (0) and the sprite engine (1).
// Optional build macro: FB_SPRITE_TRANSPARENCY_EN -- sprite pixels of colour 8'h00 are accepted
// but not written. Without it, 8'h00 is an ordinary colour.
module fb_write_scheduler #(
    parameter int unsigned WIDTH     = 264,   // columns per row (y range)
    parameter int unsigned HEIGHT    = 240,   // rows (x range)
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned PARK_ADDR = 65535  // must lie outside 0..WIDTH*HEIGHT-1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bank_sel,
    input  logic [7:0]            clear_color,
    fb_write_scheduler_if.slave   pix,
    output logic [ADDR_W-1:0]     addrWrite,
    output logic [7:0]            dataWrite,
    output logic                  busy,
    output logic                  frame_ready,
    output logic [7:0]            overrun_count
);

    localparam int unsigned        NumPix   = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] ParkAddr = ADDR_W'(PARK_ADDR);
    localparam logic [ADDR_W-1:0] LastClr  = ADDR_W'(NumPix - 1);

    typedef enum logic [1:0] {
        StWait,
        StClear,
        StDraw,
        StDone
    } state_e;

    state_e              state_q;
    logic                bank_q;
    logic                rr_last_q;  // index of the most recent winner
    logic [ADDR_W-1:0]   clr_cnt_q;

    logic                swap;
    logic                all_done;
    logic [1:0]          ready;
    logic                accept;
    logic                grant;
    logic [7:0]          sel_x;
    logic [8:0]          sel_y;
    logic [7:0]          sel_c;
    logic                in_range;
    logic                transparent;
    logic                pixel_ok;
    logic [ADDR_W-1:0]   lin_addr;

    assign swap     = (bank_sel != bank_q);
    assign all_done = &pix.req_done;

    // Round-robin grant: a contender yields only when it won last time and the other wants in.
    always_comb begin
        ready = 2'b00;
        if (state_q == StDraw && !all_done) begin
            ready[0] = pix.req_valid[0] & (~pix.req_valid[1] | (rr_last_q != 1'b0));
            ready[1] = pix.req_valid[1] & (~pix.req_valid[0] | (rr_last_q != 1'b1));
        end
    end

    assign pix.req_ready = ready;
    assign accept        = |ready;
    assign grant         = ready[1];

    // Select the winning requester's pixel and form its linear address.
    always_comb begin
        sel_x = grant ? pix.req_x[15:8]      : pix.req_x[7:0];
        sel_y = grant ? pix.req_y[17:9]      : pix.req_y[8:0];
        sel_c = grant ? pix.req_color[15:8]  : pix.req_color[7:0];
        in_range = (32'(sel_x) < HEIGHT) && (32'(sel_y) < WIDTH);
        lin_addr = ADDR_W'(sel_x) * ADDR_W'(WIDTH) + ADDR_W'(sel_y);
`ifdef FB_SPRITE_TRANSPARENCY_EN
        transparent = grant && (sel_c == 8'h00);
`else
        transparent = 1'b0;
`endif
        pixel_ok = in_range && !transparent;
    end

    assign busy        = (state_q == StClear) || (state_q == StDraw);
    assign frame_ready = (state_q == StDone);

    // Control FSM with registered write port; every branch parks unless it issues a real write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StWait;
            bank_q        <= bank_sel;
            rr_last_q     <= 1'b1;
            clr_cnt_q     <= '0;
            addrWrite     <= ParkAddr;
            dataWrite     <= 8'h00;
            overrun_count <= 8'h00;
        end else begin
            bank_q    <= bank_sel;
            addrWrite <= ParkAddr;
            dataWrite <= 8'h00;
            if (accept) begin
                rr_last_q <= grant;
            end
            if (swap) begin
                // A swap always restarts the clear; any pixel accepted now is dropped.
                if ((state_q == StClear || state_q == StDraw) && overrun_count != 8'hFF) begin
                    overrun_count <= overrun_count + 8'd1;
                end
                state_q   <= StClear;
                clr_cnt_q <= '0;
            end else begin
                unique case (state_q)
                    StClear: begin
                        addrWrite <= clr_cnt_q;
                        dataWrite <= clear_color;
                        clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
                        if (clr_cnt_q == LastClr) begin
                            state_q <= StDraw;
                        end
                    end
                    StDraw: begin
                        if (all_done) begin
                            state_q <= StDone;
                        end else if (accept && pixel_ok) begin
                            addrWrite <= lin_addr;
                            dataWrite <= sel_c;
                        end
                    end
                    default: begin
                        // WAIT and DONE hold the park address.
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/fb_write_scheduler.md
Name: fb_write_scheduler

Overview:
- Owns the write side of the ping-pong VGA frame buffer. The buffer's back bank has its write enable permanently asserted, so every cycle's address/data pair gets written.
- On each bank swap, this block clears the new back bank, then shares it between two pixel requesters (tile renderer, sprite engine) with round-robin arbitration.
- Converts (x, y) to a linear address and parks the write address on an unused location whenever no real write is wanted.
- Sits between the renderers and the frame buffer's addrWrite/dataWrite inputs.

Parameters:
- WIDTH, 264, columns per row (y range); address = x*WIDTH + y.
- HEIGHT, 240, rows (x range).
- ADDR_W, 16, write address width.
- PARK_ADDR, 65535, harmless address driven when idle; must be >= WIDTH*HEIGHT.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- bank_sel  in  1  frame buffer bank-select level (the buffer's writeEnable); any toggle = swap.
- clear_color  in  8  colour written during the clear sweep.
- req_valid  in  2  per-requester pixel valid; bit0 = tiles, bit1 = sprites.
- req_x  in  16  packed {x1[7:0], x0[7:0]} row index.
- req_y  in  18  packed {y1[8:0], y0[8:0]} column index.
- req_color  in  16  packed {c1, c0}.
- req_ready  out  2  per-requester accept; transfer when valid & ready.
- req_done  in  2  level; requester has issued all pixels for this frame.
- addrWrite  out  ADDR_W  registered write address.
- dataWrite  out  8  registered write data.
- busy  out  1  high in CLEAR or DRAW.
- frame_ready  out  1  high in DONE.
- overrun_count  out  8  saturating count of swaps that arrived before DONE.

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - state=WAIT; addrWrite=PARK_ADDR; dataWrite=0; req_ready=0; overrun_count=0; rr_last=1 (tiles win the first tie).
  - bank_q captures bank_sel.
- swap = (bank_sel != bank_q); bank_q updates every cycle.
- States:
  - WAIT: park. On swap -> CLEAR, clr_cnt=0.
  - CLEAR:
    - Each cycle registers addrWrite=clr_cnt, dataWrite=clear_color, then increments clr_cnt.
    - After the write of WIDTH*HEIGHT-1, go to DRAW.
    - Sweep takes exactly WIDTH*HEIGHT cycles (63360 at defaults).
  - DRAW:
    - req_ready is combinational. req_ready[i] = DRAW & ~&req_done & req_valid[i] & (~req_valid[~i] | rr_last != i).
    - On accept: next cycle addrWrite = x*WIDTH + y and dataWrite = colour (1-cycle latency); rr_last=i.
    - Cycle with no accept: next cycle parks.
    - When req_done == 2'b11: -> DONE. req_ready is 0 in that cycle.
  - DONE: park; frame_ready=1. On swap -> CLEAR.
- Out-of-range pixel (x >= HEIGHT or y >= WIDTH): still accepted (ready/handshake normal), but the output is parked, so no write occurs.
- Multiply: x (8b) * WIDTH into ADDR_W bits; the full in-range product fits (max 63359).
- Swap while in CLEAR or DRAW:
  - overrun_count increments, saturating at 255.
  - State restarts CLEAR with clr_cnt=0.
  - Any pixel accepted in that same cycle is dropped: output parked next cycle.
- Swap in WAIT/DONE: no overrun.
- busy = (state==CLEAR | state==DRAW).
- Reset mid-operation: immediate return to reset values; the clear in progress is abandoned.

Optional Feature:
- FB_SPRITE_TRANSPARENCY_EN.
- Defined: a requester-1 pixel with colour 8'h00 is accepted normally but produces a parked cycle (transparent, no write). Requester 0 is unaffected.
- Undefined: 8'h00 is written like any other colour.

Test Plan:
- Reset with bank_sel=1, then hold -> state WAIT, addrWrite=65535, req_ready=00, frame_ready=0.
- Toggle bank_sel, clear_color=8'h1F -> writes addr 0..63359 of 8'h1F on consecutive cycles; on the 63361st cycle, DRAW with busy=1.
- DRAW, req_valid=11 for 4 cycles, both requesters fixed (x=2,y=5,c=AA) and (x=3,y=0,c=55) -> grants alternate 0,1,0,1; addrWrite sequence 533,792,533,792, each one cycle after accept.
- Req0 x=240,y=0 accepted -> addrWrite=65535 next cycle; then req_done=11 -> DONE, frame_ready=1, req_ready=00 despite valid.
- Toggle bank_sel mid-DRAW -> overrun_count 0->1, clr_cnt restarts at 0; repeat 300 times -> count saturates at 255.
- With FB_SPRITE_TRANSPARENCY_EN: req1 c=00 at x=1,y=1 -> handshake completes, addrWrite=65535. Without the macro -> addrWrite=265, dataWrite=00.
